axis_data_unpack: RTL and testbench
===================================

# axis_data_unpack

Host-to-card counterpart of the card-to-host AXI-Stream packer. Receives frames from the DMA H2C stream, strips the leading 8-bit sequence byte from beat 0, reassembles the DATA_WIDTH-bit payload and presents it to the core through a single-entry valid/ready output register. Sits between the DMA H2C AXI-Stream port and core-side consumers. Flags malformed frames and, optionally, sequence gaps.

## Interface
- DATA_WIDTH, 16000, payload width in bits
- AXIS_DATA_WIDTH, 512, stream beat width; must be a multiple of 8 and greater than 8
- Derived AXIS_RECV_LEN = ((DATA_WIDTH + AXIS_DATA_WIDTH + 8 - 1) / AXIS_DATA_WIDTH) - 1; last beat index (31 at defaults, 32 beats per frame)

Ports:
- s_axis_h2c_aclk  in  1  sole clock
- s_axis_h2c_aresetn  in  1  asynchronous, active-low reset
- s_axis_h2c_tdata  in  AXIS_DATA_WIDTH  beat data
- s_axis_h2c_tkeep  in  64  ignored; all bytes are treated as valid
- s_axis_h2c_tlast  in  1  final beat of frame
- s_axis_h2c_tvalid  in  1  beat valid
- s_axis_h2c_tready  out  1  beat accept
- data  out  DATA_WIDTH  reassembled payload
- data_seq  out  8  sequence byte of the frame in `data`
- data_valid  out  1  `data`/`data_seq` hold a frame
- data_ready  in  1  core consumes frame
- rstate  out  2  current FSM state
- frame_err_cnt  out  8  saturating count of dropped malformed frames
- seq_err_cnt  out  8  saturating count of sequence mismatches (0 when the sequence check is compiled out)

## Operation
- Beat 0 layout: seq = tdata[7:0], payload[AXIS_DATA_WIDTH-9:0] = tdata[AXIS_DATA_WIDTH-1:8].
- Beat k ≥ 1: payload[AXIS_DATA_WIDTH-8 + (k-1)*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] = tdata. Bits beyond DATA_WIDTH in the last beat are discarded.
- Assembly register plus beat counter `cnt` (8 bits). A beat is accepted when tvalid & tready.
- States:
  - IDLE (0): tready=1. An accepted beat stores seq and slice 0. If tlast=1 there: frame error, stay IDLE. Otherwise cnt←1 and go to BODY.
  - BODY (1): tready=1. Each accepted beat stores slice cnt and increments cnt.
    - tlast=1 with cnt≠AXIS_RECV_LEN: frame error, go to IDLE, assembly discarded.
    - cnt==AXIS_RECV_LEN with tlast=0: frame error, go to DRAIN.
    - cnt==AXIS_RECV_LEN with tlast=1: frame complete. If the output is empty, or is consumed in the same cycle, load the output and go to IDLE. Otherwise go to HOLD.
  - HOLD (2): tready=0. When data_valid & data_ready, load the output next cycle and go to IDLE.
  - DRAIN (3): tready=1. Discard beats until an accepted tlast, then go to IDLE.
- Output register: data_valid sets on load and clears on data_ready unless a new frame loads in the same cycle. A same-cycle load has priority, so data_valid stays 1.
- Frame error: frame_err_cnt increments by 1, saturating at 255. A frame error never touches the output register.

## Timing
- Reset values: s_axis_h2c_tready=0 during reset and 1 in the first cycle after reset; data_valid=0; data=0; data_seq=0; rstate=0; both counters=0. Internal expected sequence=0.
- Latency: data_valid rises 1 cycle after the last beat handshake, provided the output is empty.
- Throughput: back-to-back frames are accepted with no idle cycle when data_ready is held at 1.
- HOLD exit: tready returns to 1 in the cycle after the consuming data_ready. The new data_valid is continuous with the previous one, with no gap cycle.
- Reset asserted mid-frame: everything returns to reset values immediately. The partial frame is lost and is not counted as an error.

## Configuration
- H2C_SEQ_CHECK_EN defined:
  - On each completed frame, compare seq with the expected value. A mismatch increments seq_err_cnt, saturating at 255.
  - Expected value then becomes seq+1 (mod 256), so the check resynchronises to the received seq.
  - The frame is delivered regardless.
- Undefined: no comparator and no expected-sequence register; seq_err_cnt is tied to 0.

## Test plan
- Reset, then one 32-beat frame (defaults) with seq 0x00 and payload = incrementing bytes, data_ready=1 → data_valid pulses 1 cycle after beat 31; data matches bit-exact; data_seq=0x00; both counters 0.
- Two frames back-to-back, tvalid continuous, data_ready=0 until 10 cycles after frame 2 ends → tready falls after frame 2's last beat (HOLD). Raising data_ready delivers frame 1, then frame 2 with no data_valid gap.
- tlast on beat 5 → frame_err_cnt=1, no data_valid. The next good frame is delivered correctly.
- Beat 31 without tlast, then 3 extra beats with tlast on the third → frame_err_cnt=1, DRAIN for 3 beats, following frame good.
- With H2C_SEQ_CHECK_EN defined, frames with seq 0,1,3,4 → seq_err_cnt=1 and all 4 frames delivered. Without the macro, seq_err_cnt stays 0.
- Reset asserted at beat 12 of a frame → tready=0, data_valid=0, rstate=0; a full frame after release is delivered and both counters are 0.

Source files
------------

// File: rtl/axis_data_unpack_if.sv
// H2C stream and core-side output bundle for axis_data_unpack.
// slave = unpacker view, master = DMA source plus core consumer.
interface axis_data_unpack_if #(
  parameter int DATA_WIDTH      = 16000,
  parameter int AXIS_DATA_WIDTH = 512
);
  logic [AXIS_DATA_WIDTH-1:0] s_axis_h2c_tdata;
  logic [63:0]                s_axis_h2c_tkeep;
  logic                       s_axis_h2c_tlast;
  logic                       s_axis_h2c_tvalid;
  logic                       s_axis_h2c_tready;
  logic [DATA_WIDTH-1:0]      data;
  logic [7:0]                 data_seq;
  logic                       data_valid;
  logic                       data_ready;

  modport slave (
    input  s_axis_h2c_tdata, s_axis_h2c_tkeep,
    input  s_axis_h2c_tlast, s_axis_h2c_tvalid,
    output s_axis_h2c_tready,
    output data, data_seq, data_valid,
    input  data_ready
  );

  modport master (
    output s_axis_h2c_tdata, s_axis_h2c_tkeep,
    output s_axis_h2c_tlast, s_axis_h2c_tvalid,
    input  s_axis_h2c_tready,
    input  data, data_seq, data_valid,
    output data_ready
  );
endinterface

// File: rtl/axis_data_unpack.sv
// H2C AXI-Stream frame unpacker: strips seq byte, reassembles payload.
// Optional sequence-gap counter enabled by defining H2C_SEQ_CHECK_EN.
module axis_data_unpack #(
  parameter int DATA_WIDTH      = 16000,
  parameter int AXIS_DATA_WIDTH = 512
) (
  input  logic                s_axis_h2c_aclk,
  input  logic                s_axis_h2c_aresetn,
  axis_data_unpack_if.slave   bus,
  output logic [1:0]          rstate,
  output logic [7:0]          frame_err_cnt,
  output logic [7:0]          seq_err_cnt
);

  localparam int W = AXIS_DATA_WIDTH;
  localparam int LAST =
    ((DATA_WIDTH + W + 8 - 1) / W) - 1;
  localparam int BUF_W = (LAST + 1) * W - 8;
  localparam int OFF_W = $clog2(BUF_W);
  localparam logic [7:0] LAST_CNT = 8'(LAST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BODY  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  logic clk;
  logic rst_n;
  assign clk   = s_axis_h2c_aclk;
  assign rst_n = s_axis_h2c_aresetn;

  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] seq_q, seq_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [OFF_W-1:0] off;
  logic rdy_en_q;
  logic tready;
  logic acc;
  logic ferr;
  logic load;
  logic [DATA_WIDTH-1:0] data_q;
  logic [7:0] dseq_q;
  logic valid_q;
  logic [7:0] fe_q;
  logic unused_keep;

  assign unused_keep = ^bus.s_axis_h2c_tkeep;

  // tready stays low until the first edge after reset release
  assign tready = rdy_en_q & (state_q != HOLD);
  assign acc    = bus.s_axis_h2c_tvalid & tready;

  assign bus.s_axis_h2c_tready = tready;
  assign bus.data       = data_q;
  assign bus.data_seq   = dseq_q;
  assign bus.data_valid = valid_q;
  assign rstate         = state_q;
  assign frame_err_cnt  = fe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      seq_q    <= '0;
      buf_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      seq_q    <= seq_d;
      buf_q    <= buf_d;
      rdy_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seq_d   = seq_q;
    buf_d   = buf_q;
    ferr    = 1'b0;
    load    = 1'b0;
    off     = OFF_W'(W - 8)
            + OFF_W'(cnt_q - 8'd1) * OFF_W'(W);
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          seq_d = bus.s_axis_h2c_tdata[7:0];
          buf_d[W-9:0] = bus.s_axis_h2c_tdata[W-1:8];
          if (bus.s_axis_h2c_tlast) begin
            ferr = 1'b1;
          end else begin
            cnt_d   = 8'd1;
            state_d = BODY;
          end
        end
      end
      BODY: begin
        if (acc) begin
          buf_d[off +: W] = bus.s_axis_h2c_tdata;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == LAST_CNT) begin
            if (bus.s_axis_h2c_tlast) begin
              if (!valid_q || bus.data_ready) begin
                load    = 1'b1;
                state_d = IDLE;
              end else begin
                state_d = HOLD;
              end
            end else begin
              ferr    = 1'b1;
              state_d = DRAIN;
            end
          end else if (bus.s_axis_h2c_tlast) begin
            ferr    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        if (valid_q && bus.data_ready) begin
          load    = 1'b1;
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (acc && bus.s_axis_h2c_tlast) begin
          state_d = IDLE;
        end
      end
      default: ;
    endcase
  end

  // a same-cycle load wins over consumption, keeping data_valid high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      dseq_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= '0;
    end else begin
      if (load) begin
        data_q  <= buf_d[DATA_WIDTH-1:0];
        dseq_q  <= seq_q;
        valid_q <= 1'b1;
      end else if (bus.data_ready) begin
        valid_q <= 1'b0;
      end
      if (ferr && fe_q != 8'hFF) begin
        fe_q <= fe_q + 8'd1;
      end
    end
  end

`ifdef H2C_SEQ_CHECK_EN
  logic done;
  logic [7:0] exp_q;
  logic [7:0] se_q;

  assign done = (state_q == BODY) && acc
              && (cnt_q == LAST_CNT)
              && bus.s_axis_h2c_tlast;

  // resync to the received seq so one gap counts once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q <= '0;
      se_q  <= '0;
    end else if (done) begin
      exp_q <= seq_q + 8'd1;
      if (seq_q != exp_q && se_q != 8'hFF) begin
        se_q <= se_q + 8'd1;
      end
    end
  end

  assign seq_err_cnt = se_q;
`else
  assign seq_err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_axis_data_unpack.sv
// Directed bench for axis_data_unpack at default widths.
// Frames are built from a byte pattern; deliveries go to a queue.
module tb_axis_data_unpack;

  localparam int DW = 16000;
  localparam int AW = 512;

`ifdef H2C_SEQ_CHECK_EN
  localparam logic [7:0] SEQ_ERR_EXP = 8'd1;
`else
  localparam logic [7:0] SEQ_ERR_EXP = 8'd0;
`endif

  typedef struct {
    logic [7:0]    seq;
    logic [DW-1:0] d;
  } dlv_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] rstate;
  logic [7:0] frame_err_cnt;
  logic [7:0] seq_err_cnt;
  int n_vec = 0;
  int n_err = 0;
  dlv_t q[$];

  axis_data_unpack_if #(.DATA_WIDTH(DW), .AXIS_DATA_WIDTH(AW)) bus ();

  axis_data_unpack #(.DATA_WIDTH(DW), .AXIS_DATA_WIDTH(AW)) dut (
    .s_axis_h2c_aclk    (clk),
    .s_axis_h2c_aresetn (rst_n),
    .bus                (bus),
    .rstate             (rstate),
    .frame_err_cnt      (frame_err_cnt),
    .seq_err_cnt        (seq_err_cnt)
  );

  always #5 clk = ~clk;

  // inputs change at posedge+1, so a negedge sample predicts the handshake
  always @(negedge clk) begin
    if (rst_n && bus.data_valid && bus.data_ready) begin
      q.push_back('{seq: bus.data_seq, d: bus.data});
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [7:0] salt);
    logic [DW-1:0] p;
    for (int i = 0; i < DW / 8; i++) p[i*8 +: 8] = 8'(i) + salt;
    return p;
  endfunction

  function automatic logic [AW-1:0] beat(input logic [DW-1:0] p,
                                         input logic [7:0] seq,
                                         input int k);
    logic [32*AW-1:0] x;
    x = {{(32*AW-DW){1'b0}}, p};
    if (k == 0) return {x[AW-9:0], seq};
    if (k < 32) return x[(AW-8) + (k-1)*AW +: AW];
    return {16{32'hDEADBEEF}};
  endfunction

  task automatic put(input logic [AW-1:0] d, input logic l);
    int g = 0;
    bus.s_axis_h2c_tvalid = 1'b1;
    bus.s_axis_h2c_tdata  = d;
    bus.s_axis_h2c_tlast  = l;
    @(negedge clk);
    while (!bus.s_axis_h2c_tready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) check("tready_wait", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] seq,
                            input logic [7:0] salt,
                            input int nb,
                            input int last_at,
                            input bit stop);
    logic [DW-1:0] p;
    p = mk(salt);
    for (int k = 0; k < nb; k++) put(beat(p, seq, k), k == last_at);
    if (stop) begin
      bus.s_axis_h2c_tvalid = 1'b0;
      bus.s_axis_h2c_tlast  = 1'b0;
    end
  endtask

  task automatic expect_frame(input string tag,
                              input logic [7:0] seq,
                              input logic [7:0] salt);
    int g = 0;
    int w = 0;
    bit hit = 0;
    dlv_t e;
    logic [DW-1:0] p;
    while (q.size() == 0 && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (q.size() == 0) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
      return;
    end
    e = q.pop_front();
    p = mk(salt);
    for (int i = 0; i < DW / 64; i++) begin
      if (!hit && e.d[i*64 +: 64] !== p[i*64 +: 64]) begin
        w = i;
        hit = 1;
      end
    end
    check({tag, "_seq"}, 64'(e.seq), 64'(seq));
    check({tag, "_data"}, e.d[w*64 +: 64], p[w*64 +: 64]);
  endtask

  task automatic do_reset();
    bus.s_axis_h2c_tvalid = 1'b0;
    bus.s_axis_h2c_tlast  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.s_axis_h2c_tdata  = '0;
    bus.s_axis_h2c_tkeep  = '1;
    bus.s_axis_h2c_tlast  = 1'b0;
    bus.s_axis_h2c_tvalid = 1'b0;
    bus.data_ready        = 1'b1;

    // reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_tready", 64'(bus.s_axis_h2c_tready), 64'd0);
    check("rst_valid", 64'(bus.data_valid), 64'd0);
    check("rst_data", 64'(|bus.data), 64'd0);
    check("rst_seq", 64'(bus.data_seq), 64'd0);
    check("rst_state", 64'(rstate), 64'd0);
    check("rst_ferr", 64'(frame_err_cnt), 64'd0);
    check("rst_serr", 64'(seq_err_cnt), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_tready", 64'(bus.s_axis_h2c_tready), 64'd1);

    // single frame, one-cycle latency
    send_frame(8'h00, 8'h00, 32, 31, 1);
    check("t1_valid_rise", 64'(bus.data_valid), 64'd1);
    idle(1);
    check("t1_valid_fall", 64'(bus.data_valid), 64'd0);
    expect_frame("t1", 8'h00, 8'h00);
    check("t1_ferr", 64'(frame_err_cnt), 64'd0);
    check("t1_serr", 64'(seq_err_cnt), 64'd0);

    // back-to-back frames into a stalled consumer
    do_reset();
    bus.data_ready = 1'b0;
    send_frame(8'h00, 8'h21, 32, 31, 0);
    check("t2_a_valid", 64'(bus.data_valid), 64'd1);
    send_frame(8'h01, 8'h42, 32, 31, 1);
    check("t2_hold_state", 64'(rstate), 64'd2);
    check("t2_hold_tready", 64'(bus.s_axis_h2c_tready), 64'd0);
    check("t2_hold_seq", 64'(bus.data_seq), 64'h00);
    idle(10);
    check("t2_still_hold", 64'(rstate), 64'd2);
    bus.data_ready = 1'b1;
    idle(1);
    check("t2_b_valid", 64'(bus.data_valid), 64'd1);
    check("t2_b_seq", 64'(bus.data_seq), 64'h01);
    check("t2_idle_state", 64'(rstate), 64'd0);
    check("t2_tready_back", 64'(bus.s_axis_h2c_tready), 64'd1);
    idle(1);
    check("t2_valid_fall", 64'(bus.data_valid), 64'd0);
    expect_frame("t2a", 8'h00, 8'h21);
    expect_frame("t2b", 8'h01, 8'h42);

    // early tlast
    do_reset();
    send_frame(8'h05, 8'h03, 6, 5, 1);
    check("t3_ferr", 64'(frame_err_cnt), 64'd1);
    check("t3_state", 64'(rstate), 64'd0);
    idle(3);
    check("t3_no_dlv", 64'(q.size()), 64'd0);
    check("t3_no_valid", 64'(bus.data_valid), 64'd0);
    send_frame(8'h00, 8'h07, 32, 31, 1);
    expect_frame("t3", 8'h00, 8'h07);
    check("t3_ferr_keep", 64'(frame_err_cnt), 64'd1);

    // missing tlast then drain
    do_reset();
    send_frame(8'h09, 8'h11, 32, -1, 0);
    check("t4_drain_state", 64'(rstate), 64'd3);
    check("t4_ferr", 64'(frame_err_cnt), 64'd1);
    put(beat('0, 8'h00, 40), 1'b0);
    put(beat('0, 8'h00, 41), 1'b0);
    check("t4_still_drain", 64'(rstate), 64'd3);
    put(beat('0, 8'h00, 42), 1'b1);
    bus.s_axis_h2c_tvalid = 1'b0;
    bus.s_axis_h2c_tlast  = 1'b0;
    check("t4_idle", 64'(rstate), 64'd0);
    idle(2);
    check("t4_no_dlv", 64'(q.size()), 64'd0);
    send_frame(8'h00, 8'h5A, 32, 31, 1);
    expect_frame("t4", 8'h00, 8'h5A);
    check("t4_ferr_keep", 64'(frame_err_cnt), 64'd1);

    // sequence gap 0,1,3,4
    do_reset();
    send_frame(8'h00, 8'h10, 32, 31, 0);
    send_frame(8'h01, 8'h20, 32, 31, 0);
    send_frame(8'h03, 8'h30, 32, 31, 0);
    send_frame(8'h04, 8'h40, 32, 31, 1);
    expect_frame("t5_0", 8'h00, 8'h10);
    expect_frame("t5_1", 8'h01, 8'h20);
    expect_frame("t5_3", 8'h03, 8'h30);
    expect_frame("t5_4", 8'h04, 8'h40);
    check("t5_serr", 64'(seq_err_cnt), 64'(SEQ_ERR_EXP));
    check("t5_ferr", 64'(frame_err_cnt), 64'd0);

    // reset mid-frame
    do_reset();
    send_frame(8'h00, 8'h66, 12, -1, 0);
    check("t6_body", 64'(rstate), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t6_tready", 64'(bus.s_axis_h2c_tready), 64'd0);
    check("t6_valid", 64'(bus.data_valid), 64'd0);
    check("t6_state", 64'(rstate), 64'd0);
    bus.s_axis_h2c_tvalid = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send_frame(8'h00, 8'h77, 32, 31, 1);
    expect_frame("t6", 8'h00, 8'h77);
    check("t6_ferr", 64'(frame_err_cnt), 64'd0);
    check("t6_serr", 64'(seq_err_cnt), 64'd0);
    idle(3);
    check("end_queue", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
